id_regfile_mp: RTL
==================

ID_REGFILE_MP -- requirements
Module: id_regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register and data-bus width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-004 Parameter INIT_INDEX, default 1, when 1 reset loads register i with value i (truncated to DATA_W), when 0 reset loads all zeros.
REQ-005 clk  input  1  single clock; all state changes on rising edge except reset.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  ADDR_W  write address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 ren  input  1  read enable for both read ports.
REQ-011 raddr_a  input  ADDR_W  read address, port A.
REQ-012 raddr_b  input  ADDR_W  read address, port B.
REQ-013 rdata_a  output  DATA_W  registered read data, port A.
REQ-014 rdata_b  output  DATA_W  registered read data, port B.
REQ-015 rvalid  output  1  high for the cycle after each rising edge that sampled ren=1.

Function
REQ-016 The block SHALL hold DEPTH registers of DATA_W bits with one write port and two independent read ports.
REQ-017 On a rising edge with we=1 the block SHALL store wdata into register waddr; write and read operations SHALL be fully independent (a write never suppresses a read).
REQ-018 With ZERO_REG=1 a write to address 0 SHALL be discarded and reads of address 0 SHALL return 0 on either port.
REQ-019 On a rising edge with ren=1 the block SHALL load rdata_a/rdata_b from raddr_a/raddr_b; read latency is exactly 1 cycle.
REQ-020 On a rising edge with ren=0 rdata_a/rdata_b SHALL hold their previous values and rvalid SHALL go 0.
REQ-021 rvalid SHALL equal ren registered by one cycle.
REQ-022 Both ports reading the same address in one cycle SHALL return identical data.
REQ-023 Same-edge write and read of the same nonzero address SHALL return the value defined by REQ-029/REQ-030.
REQ-024 Addresses are never out of range (DEPTH = 2**ADDR_W); no range checking SHALL exist.

Reset
REQ-025 While rst_n=0 the block SHALL asynchronously force rdata_a=0, rdata_b=0, rvalid=0.
REQ-026 While rst_n=0 every register SHALL be forced to its INIT_INDEX-defined value (register 0 = 0 regardless).
REQ-027 Reset asserted mid-operation SHALL discard any write or read on that edge; first operation takes effect on the first rising edge after rst_n rises.
REQ-028 No ready/warm-up cycles SHALL be required after reset release.

Configuration
REQ-029 With macro ID_REGFILE_BYPASS_EN defined, a read of address X on the same edge as a write to X (X nonzero or ZERO_REG=0) SHALL return the new wdata (write-first forwarding), independently per port.
REQ-030 Without ID_REGFILE_BYPASS_EN, that read SHALL return the old register content (read-first); the new value is visible from the next read.

Verification
REQ-031 Reset with INIT_INDEX=1, then ren=1, raddr_a=5, raddr_b=31 -> next cycle rdata_a=5, rdata_b=31, rvalid=1.
REQ-032 we=1, waddr=0, wdata=32'hDEADBEEF (ZERO_REG=1), then read addr 0 on both ports -> rdata_a=rdata_b=0.
REQ-033 Same edge: we=1, waddr=7, wdata=32'h12345678, ren=1, raddr_a=7 -> rdata_a=32'h12345678 with ID_REGFILE_BYPASS_EN, 7 without; next read of 7 -> 32'h12345678 in both builds.
REQ-034 Load rdata_a=9 via read, then ren=0 for 3 cycles while writing register 9 = 0xAA -> rdata_a stays 9, rvalid=0 for those cycles.
REQ-035 Write register 3 = 0x55, assert rst_n=0 between clock edges -> rdata_a/rdata_b/rvalid go 0 immediately; after release, read 3 -> 3.
REQ-036 Simultaneous we=1 waddr=12 wdata=0xF0 and ren=1 raddr_a=4 raddr_b=12 (no bypass build) -> rdata_a=4, rdata_b=12; following read of 12 -> 0xF0.

Source files
------------

// File: rtl/id_regfile_mp.sv
// id_regfile_mp: multi-ported register file with one write port, two read ports
// and registered read data with 1-cycle latency.
// Optional build macro ID_REGFILE_BYPASS_EN: when defined, a read of the address
// being written on the same edge returns the new write data (write-first);
// otherwise the old register content is returned (read-first).
module id_regfile_mp #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              rvalid_q, rvalid_d;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_a, rd_b;

    // Writes to address 0 are dropped when register 0 is hardwired.
    assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    // Next-state of the storage array.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_ok) begin
            mem_d[waddr] = wdata;
        end
    end

    // Port A read mux: zero register, optional same-edge forwarding, array.
    always_comb begin
        rd_a = mem_q[raddr_a];
`ifdef ID_REGFILE_BYPASS_EN
        if (wr_ok && (waddr == raddr_a)) begin
            rd_a = wdata;
        end
`endif
        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            rd_a = '0;
        end
    end

    // Port B read mux, identical to port A so equal addresses give equal data.
    always_comb begin
        rd_b = mem_q[raddr_b];
`ifdef ID_REGFILE_BYPASS_EN
        if (wr_ok && (waddr == raddr_b)) begin
            rd_b = wdata;
        end
`endif
        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            rd_b = '0;
        end
    end

    // Read data holds when ren is low; rvalid is ren delayed by one cycle.
    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        rvalid_d  = ren;
        if (ren) begin
            rdata_a_d = rd_a;
            rdata_b_d = rd_b;
        end
    end

    // State update; reset reloads every register with its index or zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign rvalid  = rvalid_q;

endmodule
